// File: rtl/aes16_round_ctrl.sv
// Round sequencer for the 16-bit AES datapath: whitens, iterates NR rounds through the
// shared combinational round logic, then holds the result on a valid/ready output port.
module aes16_round_ctrl #(
    parameter int NR = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [15:0] in_key,
    input  logic        in_mode,
    input  logic        flush,
    output logic [15:0] key_q,
    output logic [3:0]  rk_idx,
    input  logic [15:0] rk_data,
    output logic [15:0] dp_state,
    output logic        dp_inv,
    output logic        dp_last,
    input  logic [15:0] dp_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WHITEN = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } fsm_t;

    localparam logic [3:0] NR4 = NR[3:0];

    fsm_t        fsm_q, fsm_d;
    logic [15:0] state_q, state_d;
    logic [15:0] key_d;
    logic        mode_q, mode_d;
    logic [3:0]  rnd_q, rnd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= 16'h0000;
            key_q   <= 16'h0000;
            mode_q  <= 1'b0;
            rnd_q   <= 4'd1;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            rnd_q   <= rnd_d;
        end
    end

    // A flush only redirects the FSM; datapath registers keep whatever they held.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        mode_d  = mode_q;
        rnd_d   = rnd_q;
        rk_idx  = 4'd0;
        dp_last = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    key_d   = in_key;
                    mode_d  = in_mode;
                    rnd_d   = 4'd1;
                    fsm_d   = WHITEN;
                end
            end
            WHITEN: begin
                rk_idx = mode_q ? NR4 : 4'd0;
                if (flush) begin
                    fsm_d = IDLE;
                end else begin
                    state_d = state_q ^ rk_data;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_idx  = mode_q ? (NR4 - rnd_q) : rnd_q;
                dp_last = (rnd_q == NR4);
                if (flush) begin
                    fsm_d = IDLE;
                end else begin
                    state_d = dp_result;
                    if (rnd_q == NR4) begin
                        fsm_d = DONE;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (out_ready || flush) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE);
    assign busy      = (fsm_q != IDLE);
    assign out_valid = (fsm_q == DONE);
    assign out_data  = state_q;
    assign dp_state  = state_q;
    assign dp_inv    = mode_q;

endmodule

// File: tb/tb_aes16_round_ctrl.sv
// Self-checking bench for aes16_round_ctrl with NR=2, a toy key schedule and a toy round
// datapath; every expected value comes from a behavioural model of the cipher rules.
module tb_aes16_round_ctrl;

    localparam int NR = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_key;
    logic        in_mode;
    logic        flush;
    logic [15:0] key_q;
    logic [3:0]  rk_idx;
    logic [15:0] rk_data;
    logic [15:0] dp_state;
    logic        dp_inv;
    logic        dp_last;
    logic [15:0] dp_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    aes16_round_ctrl #(.NR(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_mode   (in_mode),
        .flush     (flush),
        .key_q     (key_q),
        .rk_idx    (rk_idx),
        .rk_data   (rk_data),
        .dp_state  (dp_state),
        .dp_inv    (dp_inv),
        .dp_last   (dp_last),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Environment models of the key schedule and the round datapath.
    assign rk_data   = 16'h0101 * ({12'd0, rk_idx} + 16'd1);
    assign dp_result = {dp_state[7:0], dp_state[15:8]} ^ rk_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] rk_of(int idx);
        logic [15:0] k;
        k = 16'(idx + 1);
        return k * 16'h0101;
    endfunction

    function automatic int key_index(int step, logic mode);
        return mode ? (NR - step) : step;
    endfunction

    function automatic logic [15:0] ref_result(logic [15:0] data, logic mode);
        logic [15:0] s;
        s = data ^ rk_of(key_index(0, mode));
        for (int r = 1; r <= NR; r++) begin
            s = {s[7:0], s[15:8]} ^ rk_of(key_index(r, mode));
        end
        return s;
    endfunction

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one block from IDLE, checking every cycle of the sequence; out_ready is
    // withheld for hold_cycles cycles while a competing block is offered.
    task automatic apply_stimulus(input logic [15:0] data, input logic mode, input int hold_cycles);
        logic [15:0] s;
        logic [15:0] key;
        key      = 16'($urandom);
        in_data  = data;
        in_mode  = mode;
        in_key   = key;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check_output("accept_ready", {15'd0, in_ready}, 16'd1);
        tick();
        in_valid = 1'b0;
        check_output("whiten_idx", {12'd0, rk_idx}, 16'(key_index(0, mode)));
        check_output("whiten_state", dp_state, data);
        check_output("whiten_key", key_q, key);
        check_output("whiten_busy", {15'd0, busy}, 16'd1);
        s = data ^ rk_of(key_index(0, mode));
        tick();
        for (int r = 1; r <= NR; r++) begin
            check_output("round_state", dp_state, s);
            check_output("round_idx", {12'd0, rk_idx}, 16'(key_index(r, mode)));
            check_output("round_last", {15'd0, dp_last}, (r == NR) ? 16'd1 : 16'd0);
            check_output("round_inv", {15'd0, dp_inv}, {15'd0, mode});
            check_output("round_valid", {15'd0, out_valid}, 16'd0);
            s = {s[7:0], s[15:8]} ^ rk_of(key_index(r, mode));
            tick();
        end
        check_output("done_valid", {15'd0, out_valid}, 16'd1);
        check_output("done_data", out_data, ref_result(data, mode));
        check_output("done_idx", {12'd0, rk_idx}, 16'd0);
        for (int h = 0; h < hold_cycles; h++) begin
            in_valid = 1'b1;
            in_data  = 16'hFFFF;
            tick();
            check_output("hold_valid", {15'd0, out_valid}, 16'd1);
            check_output("hold_data", out_data, s);
            check_output("hold_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("post_ready", {15'd0, in_ready}, 16'd1);
        check_output("post_valid", {15'd0, out_valid}, 16'd0);
        check_output("post_busy", {15'd0, busy}, 16'd0);
        check_output("post_state_kept", dp_state, s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_in_ready"}, {15'd0, in_ready}, 16'd1);
        check_output({tag, "_out_valid"}, {15'd0, out_valid}, 16'd0);
        check_output({tag, "_busy"}, {15'd0, busy}, 16'd0);
        check_output({tag, "_rk_idx"}, {12'd0, rk_idx}, 16'd0);
        check_output({tag, "_dp_last"}, {15'd0, dp_last}, 16'd0);
        check_output({tag, "_dp_inv"}, {15'd0, dp_inv}, 16'd0);
        check_output({tag, "_out_data"}, out_data, 16'd0);
        check_output({tag, "_key_q"}, key_q, 16'd0);
    endtask

    initial begin
        logic [15:0] exp_q[$];
        int          last_acc;
        int          n_acc;
        int          n_out;
        logic        took;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        in_key    = 16'h0000;
        in_mode   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #3;
        check_reset_outputs("reset");
        #9;
        rst_n = 1'b1;
        tick();

        $display("[TB] directed encrypt and decrypt of 1234");
        apply_stimulus(16'h1234, 1'b0, 0);
        apply_stimulus(16'h1234, 1'b1, 0);

        $display("[TB] output back-pressure for 10 cycles");
        apply_stimulus(16'h5A5A, 1'b0, 10);

        $display("[TB] flush in first round");
        in_data  = 16'h0F0F;
        in_mode  = 1'b0;
        in_key   = 16'h1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush_ready", {15'd0, in_ready}, 16'd1);
        check_output("flush_valid", {15'd0, out_valid}, 16'd0);
        check_output("flush_busy", {15'd0, busy}, 16'd0);
        apply_stimulus(16'hABCD, 1'b0, 0);

        $display("[TB] flush in IDLE does not block accept");
        in_data  = 16'h2468;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_output("idle_flush_accept", {15'd0, busy}, 16'd1);
        check_output("idle_flush_state", dp_state, 16'h2468);
        repeat (NR + 1) tick();
        check_output("idle_flush_done", out_data, ref_result(16'h2468, 1'b0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        $display("[TB] async reset mid-round");
        in_data  = 16'hC3C3;
        in_mode  = 1'b1;
        in_key   = 16'h7777;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check_output("pre_reset_inv", {15'd0, dp_inv}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        check_output("async_reset_state", dp_state, 16'd0);
        #1;
        rst_n = 1'b1;
        tick();
        apply_stimulus(16'h9E37, 1'b1, 0);

        $display("[TB] randomized blocks");
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] back-to-back blocks");
        last_acc  = -1;
        n_acc     = 0;
        n_out     = 0;
        in_data   = 16'($urandom);
        in_mode   = 1'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            took = 1'b0;
            if (in_ready && in_valid) begin
                if (last_acc >= 0) begin
                    check_output("b2b_spacing", 16'(c - last_acc), 16'(NR + 3));
                end
                last_acc = c;
                exp_q.push_back(ref_result(in_data, in_mode));
                n_acc++;
                took = 1'b1;
            end
            if (out_valid) begin
                if (exp_q.size() > 0) begin
                    check_output("b2b_data", out_data, exp_q.pop_front());
                end else begin
                    check_output("b2b_unexpected_out", 16'd1, 16'd0);
                end
                n_out++;
            end
            tick();
            if (took) begin
                in_data  = 16'($urandom);
                in_mode  = 1'($urandom);
                in_valid = (n_acc < 4);
            end
        end
        out_ready = 1'b0;
        check_output("b2b_accepts", 16'(n_acc), 16'd4);
        check_output("b2b_outputs", 16'(n_out), 16'd4);
        check_output("b2b_drained", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/aes16_round_ctrl.md
# aes16_round_ctrl

Round sequencer for the 16-bit AES encrypt/decrypt datapath. It accepts one 16-bit block and key per transaction and iterates the shared combinational round logic (sub-nibble, shift-row, mix-column, add-round-key) once per cycle, holding the state register between rounds. It drives the round-key index to the key schedule and delivers the finished block over a valid/ready output port. It sits between the block I/O and the round datapath in the ENC-DEC top level.

## Interface
- NR, 2, number of rounds; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input block offered.
- in_ready  output  1  controller can accept a block; high only in IDLE.
- in_data  input  16  plaintext or ciphertext.
- in_key  input  16  cipher key; registered at accept.
- in_mode  input  1  0 = encrypt, 1 = decrypt; registered at accept.
- flush  input  1  synchronous abort of the block in flight.
- key_q  output  16  registered key, fed to the key schedule.
- rk_idx  output  4  round-key index requested from the key schedule.
- rk_data  input  16  round key for rk_idx, combinational from the key schedule.
- dp_state  output  16  current state into the round datapath (equals state_q).
- dp_inv  output  1  registered mode; selects the inverse round.
- dp_last  output  1  final round; the datapath omits mix-column.
- dp_result  input  16  combinational round output, key already added.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  16  result block (equals state_q).
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WHITEN, ROUND, DONE.
- IDLE: in_ready=1. On in_valid: state_q<=in_data, key_q<=in_key, mode_q<=in_mode, rnd_q<=1, go to WHITEN.
- WHITEN: rk_idx = mode_q ? NR : 0. state_q <= state_q ^ rk_data. Go to ROUND.
- ROUND: rk_idx = mode_q ? NR-rnd_q : rnd_q; dp_last = (rnd_q==NR); state_q <= dp_result.
  - rnd_q<NR: rnd_q increments.
  - rnd_q==NR: go to DONE.
- DONE: out_valid=1, out_data=state_q stable. On out_ready, go to IDLE.
- A new block is never accepted in DONE, even in the handshake cycle. in_ready rises the cycle after the output handshake.
- flush in WHITEN, ROUND or DONE: go to IDLE next cycle and discard the block. state_q, key_q and rnd_q keep their values.
  - flush with out_ready in DONE: the output transfer counts. The controller goes to IDLE.
  - flush in IDLE: no effect. in_valid in the same cycle is still accepted; flush does not block the accept.
- rk_idx is 0 in IDLE and DONE. dp_last is 0 outside ROUND.
- rnd_q is 4 bits wide. Index arithmetic is unsigned 4-bit and never wraps for legal NR.
- Reset (async, any state): state IDLE, state_q=0, key_q=0, mode_q=0, rnd_q=1. Outputs: in_ready=1, out_valid=0, busy=0, rk_idx=0, dp_last=0, dp_inv=0, out_data=0, dp_state=0. The block in flight is lost.

## Timing
- Accept in cycle T. WHITEN in T+1. ROUND in T+2..T+1+NR. out_valid first high in T+2+NR.
- out_valid stays high, with out_data unchanged, until out_ready is sampled high.
- With out_ready held high, the minimum period is NR+3 cycles per block.
- rk_data and dp_result are used in the same cycle rk_idx and dp_state are presented. That is one combinational round per cycle.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid or out_ready to any output.

## Test plan
The bench uses NR=2 and these models:
- rk_data = 16'h0101*(rk_idx+1).
- dp_result = {dp_state[7:0], dp_state[15:8]} ^ rk_data.

Scenarios:
- Encrypt 16'h1234 with out_ready=1 -> rk_idx sequence 0,1,2 and states 1335, 3711. out_valid rises at T+4 with out_data=16'h1234; in_ready returns at T+5.
- Decrypt 16'h1234 -> rk_idx sequence 2,1,0 and states 1137, 3513. Result 16'h1234 at T+4. dp_inv=1 and dp_last=1 only in the second ROUND cycle.
- out_ready held low for 10 cycles after out_valid -> out_valid and out_data stay stable, in_ready stays 0, and a second in_valid is ignored. Release -> one transfer, then IDLE.
- flush in the first ROUND cycle -> IDLE next cycle with no out_valid. A following block 16'hABCD is encrypted correctly.
- rst_n pulsed low mid-ROUND (async, between clock edges) -> all outputs take their reset values immediately. Recovery after release: a new block completes with latency NR+2.
- Back-to-back blocks with in_valid and out_ready always high -> accepts spaced exactly NR+3 cycles apart, with no dropped or duplicated output.
